// File: rtl/toy_phy_rf_status_bank.sv
// Status bank for the whole physical register file: idle/backup/ready/forward-id per entry plus a free-entry picker.
// Define TOY_PRF_ZERO_REG_EN to hardwire entry 0 as a read-only zero register (INT bank x0).
module toy_phy_rf_status_bank #(
    parameter int ENTRY_NUM = 96,
    parameter int ARCH_NUM  = 32,
    parameter int ALLOC_NUM = 4,
    parameter int WB_NUM    = 4,
    parameter int CMT_NUM   = 4,
    parameter int FWD_NUM   = 3,
    parameter int EU_W      = 3,
    localparam int ID_W     = $clog2(ENTRY_NUM),
    localparam int CNT_W    = $clog2(ENTRY_NUM + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ALLOC_NUM-1:0]         alloc_req,
    output logic                         alloc_gnt,
    output logic [ALLOC_NUM*ID_W-1:0]    alloc_id,
    output logic [CNT_W-1:0]             free_cnt,
    input  logic [WB_NUM-1:0]            fwd_en,
    input  logic [WB_NUM*ID_W-1:0]       fwd_pid,
    input  logic [WB_NUM*EU_W-1:0]       fwd_eu,
    input  logic [WB_NUM-1:0]            wb_en,
    input  logic [WB_NUM*ID_W-1:0]       wb_pid,
    input  logic [CMT_NUM-1:0]           ref_en,
    input  logic [CMT_NUM*ID_W-1:0]      ref_pid,
    input  logic [CMT_NUM-1:0]           rel_en,
    input  logic [CMT_NUM*ID_W-1:0]      rel_pid,
    input  logic                         cancel_en,
    output logic [ENTRY_NUM-1:0]         entry_idle,
    output logic [ENTRY_NUM*FWD_NUM-1:0] rdy_oh,
    output logic [ENTRY_NUM-1:0]         rdy,
    output logic [ENTRY_NUM*EU_W-1:0]    fwd_id
);

    localparam logic [FWD_NUM-1:0] RDY_ONE = FWD_NUM'(1);
    localparam logic [FWD_NUM-1:0] RDY_MSB = RDY_ONE << (FWD_NUM - 1);

    logic [ENTRY_NUM-1:0] idle_q, idle_d;
    logic [ENTRY_NUM-1:0] backup_q, backup_d;
    logic [FWD_NUM-1:0]   rdy_q [ENTRY_NUM];
    logic [FWD_NUM-1:0]   rdy_d [ENTRY_NUM];
    logic [EU_W-1:0]      fwd_q [ENTRY_NUM];
    logic [EU_W-1:0]      fwd_d [ENTRY_NUM];
    logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;
    logic [ENTRY_NUM-1:0] avail;
    logic [ENTRY_NUM-1:0] gnt_vec;
    logic [ID_W-1:0]      pick_id [ALLOC_NUM];
    logic [CNT_W-1:0]     req_cnt;
    logic                 dup_err;

    // Only entries idle at the start of the cycle are allocatable; same-cycle frees wait a cycle.
    always_comb begin
        avail = idle_q;
`ifdef TOY_PRF_ZERO_REG_EN
        avail[0] = 1'b0;
`endif
    end

    always_comb begin : picker
        int seen;
        int slot;
        req_cnt = '0;
        for (int p = 0; p < ALLOC_NUM; p++) req_cnt = req_cnt + CNT_W'(alloc_req[p]);
        alloc_gnt = (free_cnt_q >= req_cnt) && !cancel_en && !rst;
        for (int a = 0; a < ALLOC_NUM; a++) pick_id[a] = '0;
        gnt_vec = '0;
        seen = 0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (avail[i]) begin
                if (seen < ALLOC_NUM) pick_id[seen] = ID_W'(i);
                if (alloc_gnt && seen < int'(req_cnt)) gnt_vec[i] = 1'b1;
                seen = seen + 1;
            end
        end
        alloc_id = '0;
        slot = 0;
        for (int p = 0; p < ALLOC_NUM; p++) begin
            if (alloc_req[p]) begin
                alloc_id[p*ID_W +: ID_W] = pick_id[slot];
                slot = slot + 1;
            end
        end
    end

    always_comb begin : next_state
        logic            rel_hit, ref_hit, wb_hit, fwd_hit, cancel_free;
        logic [EU_W-1:0] eu_sel;
        rel_hit = 1'b0; ref_hit = 1'b0; wb_hit = 1'b0; fwd_hit = 1'b0; cancel_free = 1'b0;
        eu_sel = '0;
        idle_d = idle_q;
        backup_d = backup_q;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            rel_hit = 1'b0; ref_hit = 1'b0; wb_hit = 1'b0; fwd_hit = 1'b0;
            eu_sel = '0;
            for (int p = 0; p < CMT_NUM; p++) begin
                if (rel_en[p] && rel_pid[p*ID_W +: ID_W] == ID_W'(i)) rel_hit = 1'b1;
                if (ref_en[p] && ref_pid[p*ID_W +: ID_W] == ID_W'(i)) ref_hit = 1'b1;
            end
            for (int p = 0; p < WB_NUM; p++)
                if (wb_en[p] && wb_pid[p*ID_W +: ID_W] == ID_W'(i)) wb_hit = 1'b1;
            // Walk downwards so the lowest forwarding port's EU id is the one kept.
            for (int p = WB_NUM - 1; p >= 0; p--) begin
                if (fwd_en[p] && fwd_pid[p*ID_W +: ID_W] == ID_W'(i)) begin
                    fwd_hit = 1'b1;
                    eu_sel  = fwd_eu[p*EU_W +: EU_W];
                end
            end
            cancel_free = cancel_en && !backup_q[i] && !ref_hit;

            idle_d[i]   = (rel_hit || cancel_free) ? 1'b1 : (gnt_vec[i] ? 1'b0 : idle_q[i]);
            backup_d[i] = rel_hit ? 1'b0 : (ref_hit ? 1'b1 : backup_q[i]);
            if (cancel_free)                           rdy_d[i] = RDY_ONE;
            else if (fwd_hit)                          rdy_d[i] = RDY_MSB;
            else if (wb_hit)                           rdy_d[i] = RDY_ONE;
            else if (rdy_q[i] != '0 && !rdy_q[i][0])   rdy_d[i] = rdy_q[i] >> 1;
            else if (gnt_vec[i])                       rdy_d[i] = '0;
            else                                       rdy_d[i] = rdy_q[i];
            fwd_d[i] = fwd_hit ? eu_sel : fwd_q[i];
`ifdef TOY_PRF_ZERO_REG_EN
            if (i == 0) begin
                idle_d[i]   = 1'b0;
                backup_d[i] = 1'b1;
                rdy_d[i]    = RDY_ONE;
                fwd_d[i]    = '0;
            end
`endif
        end
    end

    // Free count tracks idle transitions so it can never drift from the idle vector.
    always_comb begin : count
        logic [CNT_W:0] up, down;
        up = '0;
        down = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            up   = up   + {{CNT_W{1'b0}}, idle_d[i] & ~idle_q[i]};
            down = down + {{CNT_W{1'b0}}, idle_q[i] & ~idle_d[i]};
        end
        free_cnt_d = CNT_W'({1'b0, free_cnt_q} + up - down);
    end

    always_comb begin : dup_check
        dup_err = 1'b0;
        for (int p = 0; p < WB_NUM; p++)
            for (int q = p + 1; q < WB_NUM; q++)
                if (wb_en[p] && wb_en[q] && wb_pid[p*ID_W +: ID_W] == wb_pid[q*ID_W +: ID_W]) dup_err = 1'b1;
        for (int p = 0; p < CMT_NUM; p++)
            for (int q = p + 1; q < CMT_NUM; q++) begin
                if (ref_en[p] && ref_en[q] && ref_pid[p*ID_W +: ID_W] == ref_pid[q*ID_W +: ID_W]) dup_err = 1'b1;
                if (rel_en[p] && rel_en[q] && rel_pid[p*ID_W +: ID_W] == rel_pid[q*ID_W +: ID_W]) dup_err = 1'b1;
            end
    end

    assert property (@(posedge clk) disable iff (rst) !dup_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                idle_q[i]   <= (i >= ARCH_NUM);
                backup_q[i] <= (i < ARCH_NUM);
                rdy_q[i]    <= RDY_ONE;
                fwd_q[i]    <= '0;
            end
            free_cnt_q <= CNT_W'(ENTRY_NUM - ARCH_NUM);
        end else begin
            idle_q     <= idle_d;
            backup_q   <= backup_d;
            rdy_q      <= rdy_d;
            fwd_q      <= fwd_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    always_comb begin
        rdy_oh = '0;
        rdy    = '0;
        fwd_id = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            rdy_oh[i*FWD_NUM +: FWD_NUM] = rdy_q[i];
            rdy[i]                       = |rdy_q[i];
            fwd_id[i*EU_W +: EU_W]       = fwd_q[i];
        end
    end

    assign entry_idle = idle_q;
    assign free_cnt   = free_cnt_q;

endmodule

// File: tb/tb_toy_phy_rf_status_bank.sv
// Testbench for toy_phy_rf_status_bank: scripted scenarios, expected values queued on a scoreboard.
// Build with TOY_PRF_ZERO_REG_EN defined to exercise the zero-register variant.
`timescale 1ns/1ps
module tb_toy_phy_rf_status_bank;

    localparam int ENTRY_NUM = 96;
    localparam int ARCH_NUM  = 32;
    localparam int ALLOC_NUM = 4;
    localparam int WB_NUM    = 4;
    localparam int CMT_NUM   = 4;
    localparam int FWD_NUM   = 3;
    localparam int EU_W      = 3;
    localparam int ID_W      = $clog2(ENTRY_NUM);
    localparam int CNT_W     = $clog2(ENTRY_NUM + 1);

    localparam int K_FREE = 0, K_IDLE = 1, K_RDYOH = 2, K_RDY = 3, K_FWDID = 4, K_GNT = 5, K_AID = 6;

`ifdef TOY_PRF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic                         clk;
    logic                         rst;
    logic [ALLOC_NUM-1:0]         alloc_req;
    logic                         alloc_gnt;
    logic [ALLOC_NUM*ID_W-1:0]    alloc_id;
    logic [CNT_W-1:0]             free_cnt;
    logic [WB_NUM-1:0]            fwd_en;
    logic [WB_NUM*ID_W-1:0]       fwd_pid;
    logic [WB_NUM*EU_W-1:0]       fwd_eu;
    logic [WB_NUM-1:0]            wb_en;
    logic [WB_NUM*ID_W-1:0]       wb_pid;
    logic [CMT_NUM-1:0]           ref_en;
    logic [CMT_NUM*ID_W-1:0]      ref_pid;
    logic [CMT_NUM-1:0]           rel_en;
    logic [CMT_NUM*ID_W-1:0]      rel_pid;
    logic                         cancel_en;
    logic [ENTRY_NUM-1:0]         entry_idle;
    logic [ENTRY_NUM*FWD_NUM-1:0] rdy_oh;
    logic [ENTRY_NUM-1:0]         rdy;
    logic [ENTRY_NUM*EU_W-1:0]    fwd_id;

    typedef struct {
        string tag;
        int    kind;
        int    idx;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    toy_phy_rf_status_bank #(
        .ENTRY_NUM(ENTRY_NUM), .ARCH_NUM(ARCH_NUM), .ALLOC_NUM(ALLOC_NUM),
        .WB_NUM(WB_NUM), .CMT_NUM(CMT_NUM), .FWD_NUM(FWD_NUM), .EU_W(EU_W)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id), .free_cnt(free_cnt),
        .fwd_en(fwd_en), .fwd_pid(fwd_pid), .fwd_eu(fwd_eu),
        .wb_en(wb_en), .wb_pid(wb_pid),
        .ref_en(ref_en), .ref_pid(ref_pid), .rel_en(rel_en), .rel_pid(rel_pid),
        .cancel_en(cancel_en),
        .entry_idle(entry_idle), .rdy_oh(rdy_oh), .rdy(rdy), .fwd_id(fwd_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] observe(input int kind, input int idx);
        case (kind)
            K_FREE:  return 32'(free_cnt);
            K_IDLE:  return 32'(entry_idle[idx]);
            K_RDYOH: return 32'(rdy_oh[idx*FWD_NUM +: FWD_NUM]);
            K_RDY:   return 32'(rdy[idx]);
            K_FWDID: return 32'(fwd_id[idx*EU_W +: EU_W]);
            K_GNT:   return 32'(alloc_gnt);
            K_AID:   return 32'(alloc_id[idx*ID_W +: ID_W]);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic pushExpect(input string tag, input int kind, input int idx, input int val);
        exp_t e;
        e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drainScoreboard();
        exp_t e;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput(e.tag, observe(e.kind, e.idx), 32'(e.val));
        end
    endtask

    task automatic checkComb();
        #1;
        drainScoreboard();
    endtask

    task automatic clearInputs();
        alloc_req = '0; fwd_en = '0; fwd_pid = '0; fwd_eu = '0;
        wb_en = '0; wb_pid = '0; ref_en = '0; ref_pid = '0;
        rel_en = '0; rel_pid = '0; cancel_en = 1'b0;
    endtask

    // One clock with the currently driven inputs, then compare everything queued for after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearInputs();
        drainScoreboard();
    endtask

    task automatic setFwd(input int port, input int pid, input int eu);
        fwd_en[port] = 1'b1;
        fwd_pid[port*ID_W +: ID_W] = ID_W'(pid);
        fwd_eu[port*EU_W +: EU_W]  = EU_W'(eu);
    endtask

    task automatic setWb(input int port, input int pid);
        wb_en[port] = 1'b1;
        wb_pid[port*ID_W +: ID_W] = ID_W'(pid);
    endtask

    task automatic setRef(input int port, input int pid);
        ref_en[port] = 1'b1;
        ref_pid[port*ID_W +: ID_W] = ID_W'(pid);
    endtask

    task automatic setRel(input int port, input int pid);
        rel_en[port] = 1'b1;
        rel_pid[port*ID_W +: ID_W] = ID_W'(pid);
    endtask

    initial begin
        bit model_idle [ENTRY_NUM];
        int free_model;
        int n;
        int pick;

        clearInputs();
        rst = 1'b1;
        alloc_req = 4'b0001;
        pushExpect("gnt_during_reset", K_GNT, 0, 0);
        checkComb();
        pushExpect("reset_free_cnt", K_FREE, 0, 64);
        pushExpect("reset_idle0", K_IDLE, 0, 0);
        pushExpect("reset_idle31", K_IDLE, 31, 0);
        pushExpect("reset_idle32", K_IDLE, 32, 1);
        pushExpect("reset_idle95", K_IDLE, 95, 1);
        pushExpect("reset_rdyoh0", K_RDYOH, 0, 1);
        pushExpect("reset_rdyoh50", K_RDYOH, 50, 1);
        pushExpect("reset_rdy95", K_RDY, 95, 1);
        pushExpect("reset_fwdid40", K_FWDID, 40, 0);
        applyStimulus();
        rst = 1'b0;

        // First allocation: ports 0,1,3 request.
        alloc_req = 4'b1011;
        pushExpect("alloc_gnt_1011", K_GNT, 0, 1);
        pushExpect("alloc_id_p0", K_AID, 0, 32);
        pushExpect("alloc_id_p1", K_AID, 1, 33);
        pushExpect("alloc_id_p2", K_AID, 2, 0);
        pushExpect("alloc_id_p3", K_AID, 3, 34);
        checkComb();
        pushExpect("alloc_free_cnt", K_FREE, 0, 61);
        pushExpect("alloc_idle32", K_IDLE, 32, 0);
        pushExpect("alloc_idle34", K_IDLE, 34, 0);
        pushExpect("alloc_idle35", K_IDLE, 35, 1);
        pushExpect("alloc_rdyoh32", K_RDYOH, 32, 0);
        pushExpect("alloc_rdy33", K_RDY, 33, 0);
        pushExpect("alloc_rdy34", K_RDY, 34, 0);
        applyStimulus();

        // Forward countdown, fwd-over-wb priority, and lowest port winning the EU id.
        setFwd(1, 32, 5);
        setFwd(2, 34, 3);
        setFwd(3, 34, 6);
        setWb(0, 33);
        setWb(2, 32);
        pushExpect("fwd_rdyoh32_c1", K_RDYOH, 32, 4);
        pushExpect("fwd_fwdid32", K_FWDID, 32, 5);
        pushExpect("fwd_rdy32_c1", K_RDY, 32, 1);
        pushExpect("fwd_fwdid34_lowport", K_FWDID, 34, 3);
        pushExpect("fwd_rdyoh34_c1", K_RDYOH, 34, 4);
        pushExpect("wb_rdyoh33", K_RDYOH, 33, 1);
        pushExpect("fwd_free_cnt", K_FREE, 0, 61);
        applyStimulus();
        pushExpect("fwd_rdyoh32_c2", K_RDYOH, 32, 2);
        pushExpect("fwd_rdy32_c2", K_RDY, 32, 1);
        pushExpect("fwd_rdyoh34_c2", K_RDYOH, 34, 2);
        applyStimulus();
        pushExpect("fwd_rdyoh32_c3", K_RDYOH, 32, 1);
        pushExpect("fwd_rdy32_c3", K_RDY, 32, 1);
        applyStimulus();
        pushExpect("fwd_rdyoh32_hold", K_RDYOH, 32, 1);
        applyStimulus();

        // Flush with a same-cycle commit ref on 33.
        setRef(2, 33);
        cancel_en = 1'b1;
        alloc_req = 4'b0001;
        pushExpect("cancel_gnt", K_GNT, 0, 0);
        checkComb();
        pushExpect("cancel_idle32", K_IDLE, 32, 1);
        pushExpect("cancel_idle34", K_IDLE, 34, 1);
        pushExpect("cancel_idle33_kept", K_IDLE, 33, 0);
        pushExpect("cancel_rdyoh32", K_RDYOH, 32, 1);
        pushExpect("cancel_rdyoh34", K_RDYOH, 34, 1);
        pushExpect("cancel_idle5_arch", K_IDLE, 5, 0);
        pushExpect("cancel_fwdid32", K_FWDID, 32, 5);
        pushExpect("cancel_free_cnt", K_FREE, 0, 63);
        applyStimulus();

        // Drain down to two free entries, predicting ids from a lowest-free model.
        free_model = 0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            model_idle[i] = (i >= ARCH_NUM) && (i != 33);
            if (model_idle[i]) free_model++;
        end
        while (free_model > 2) begin
            n = (free_model - 2 >= ALLOC_NUM) ? ALLOC_NUM : free_model - 2;
            alloc_req = ALLOC_NUM'((1 << n) - 1);
            pick = 0;
            for (int i = 0; i < ENTRY_NUM && pick < n; i++) begin
                if (model_idle[i]) begin
                    pushExpect("drain_id", K_AID, pick, i);
                    model_idle[i] = 1'b0;
                    pick++;
                end
            end
            pushExpect("drain_gnt", K_GNT, 0, 1);
            checkComb();
            free_model -= n;
            pushExpect("drain_free_cnt", K_FREE, 0, free_model);
            applyStimulus();
        end
        pushExpect("drain_idle95_left", K_IDLE, 95, model_idle[95] ? 1 : 0);
        pushExpect("drain_idle93_taken", K_IDLE, 93, model_idle[93] ? 1 : 0);
        checkComb();

        // Too few free entries: refused, while a same-cycle release still counts.
        alloc_req = 4'b0111;
        setRel(1, 5);
        pushExpect("short_gnt", K_GNT, 0, 0);
        checkComb();
        pushExpect("short_free_cnt", K_FREE, 0, 3);
        pushExpect("rel_idle5", K_IDLE, 5, 1);
        applyStimulus();
        model_idle[5] = 1'b1;

        alloc_req = 4'b0111;
        pick = 0;
        for (int i = 0; i < ENTRY_NUM && pick < 3; i++) begin
            if (model_idle[i]) begin
                pushExpect("fill_id", K_AID, pick, i);
                model_idle[i] = 1'b0;
                pick++;
            end
        end
        pushExpect("fill_gnt", K_GNT, 0, 1);
        checkComb();
        pushExpect("fill_free_cnt", K_FREE, 0, 0);
        pushExpect("fill_idle5", K_IDLE, 5, 0);
        applyStimulus();

        alloc_req = 4'b0001;
        pushExpect("empty_gnt", K_GNT, 0, 0);
        checkComb();
        alloc_req = 4'b0000;
        pushExpect("zero_req_gnt", K_GNT, 0, 1);
        checkComb();
        pushExpect("zero_req_free_cnt", K_FREE, 0, 0);
        applyStimulus();

        // Release beats ref on the same entry.
        setRef(0, 40);
        setRel(3, 40);
        pushExpect("relref_idle40", K_IDLE, 40, 1);
        pushExpect("relref_free_cnt", K_FREE, 0, 1);
        applyStimulus();

        // Reset mid-operation discards that cycle's requests.
        rst = 1'b1;
        alloc_req = 4'b1111;
        setRel(0, 7);
        pushExpect("midrst_gnt", K_GNT, 0, 0);
        checkComb();
        pushExpect("midrst_free_cnt", K_FREE, 0, 64);
        pushExpect("midrst_idle7", K_IDLE, 7, 0);
        pushExpect("midrst_idle31", K_IDLE, 31, 0);
        pushExpect("midrst_idle33", K_IDLE, 33, 1);
        pushExpect("midrst_rdyoh40", K_RDYOH, 40, 1);
        pushExpect("midrst_fwdid32", K_FWDID, 32, 0);
        applyStimulus();
        rst = 1'b0;

        // Entry 0 is a normal entry unless the zero register is configured.
        setRel(2, 0);
        setWb(1, 0);
        pushExpect("zero_idle0", K_IDLE, 0, ZERO_REG ? 0 : 1);
        pushExpect("zero_rdyoh0", K_RDYOH, 0, 1);
        pushExpect("zero_free_cnt", K_FREE, 0, ZERO_REG ? 64 : 65);
        applyStimulus();

        alloc_req = 4'b0001;
        pushExpect("zero_alloc_id", K_AID, 0, ZERO_REG ? 32 : 0);
        pushExpect("zero_alloc_gnt", K_GNT, 0, 1);
        checkComb();
        pushExpect("zero_alloc_free_cnt", K_FREE, 0, ZERO_REG ? 63 : 64);
        pushExpect("zero_alloc_idle0", K_IDLE, 0, 0);
        applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
